// File: rtl/demux_1to4_stream_pkg.sv
// Shared types and constants for the packet-aware 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } route_state_t;

    // One-hot decode of a destination index onto the output valid lanes.
    function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] oh;
        oh      = {NUM_OUT{1'b0}};
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to4_stream_if.sv
// Handshake bundle between a producer, the demux and its four consumers.
interface demux_1to4_stream_if #(parameter int DATA_W = 8);
    import demux_pkg::*;

    logic [DATA_W-1:0]  in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic               busy;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid, busy
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid, busy
    );

endinterface

// File: rtl/demux_1to4_stream_reg_slice.sv
// One-entry register slice with pass-through ready: refills on the same edge it drains.
module stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_payload,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_payload,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] payload_q;
    logic [W-1:0] payload_d;

    // Slot next-state: load on accept, otherwise empty on drain, otherwise hold.
    always_comb begin
        in_ready  = !full_q || out_ready;
        full_d    = full_q;
        payload_d = payload_q;
        if (in_valid && in_ready) begin
            full_d    = 1'b1;
            payload_d = in_payload;
        end else if (out_ready) begin
            full_d    = 1'b0;
        end else begin
            full_d    = full_q;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            payload_q <= {W{1'b0}};
        end else begin
            full_q    <= full_d;
            payload_q <= payload_d;
        end
    end

    assign out_payload = payload_q;
    assign out_valid   = full_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// Packet-aware 1-to-4 demux: route captured on a packet's first beat, held until its last beat.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_1to4_stream_if.slave  bus
);

    localparam int PAY_W = SEL_W + 1 + DATA_W;

    route_state_t     state_q;
    route_state_t     state_d;
    logic [SEL_W-1:0] route_q;
    logic [SEL_W-1:0] route_d;
    logic [SEL_W-1:0] eff_sel_s;
    logic             accept_s;

    logic [PAY_W-1:0] slot_in_s;
    logic [PAY_W-1:0] slot_out_s;
    logic             slot_in_ready_s;
    logic             slot_valid_s;
    logic [SEL_W-1:0] slot_dest_s;

    assign accept_s    = bus.in_valid && slot_in_ready_s;
    assign slot_dest_s = slot_out_s[PAY_W-1 -: SEL_W];
    assign slot_in_s   = {eff_sel_s, bus.in_last, bus.in_data};

    // Route FSM next-state; in LOCKED the live in_sel is ignored.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        eff_sel_s = route_q;
        case (state_q)
            IDLE: begin
                eff_sel_s = bus.in_sel;
                if (accept_s) begin
                    route_d = bus.in_sel;
                    if (bus.in_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && bus.in_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
                route_d = {SEL_W{1'b0}};
            end
        endcase
    end

    // Route FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            route_q <= {SEL_W{1'b0}};
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // Only the consumer the slot is destined for can drain it.
    stream_reg_slice #(.W(PAY_W)) u_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_payload  (slot_in_s),
        .in_valid    (bus.in_valid),
        .in_ready    (slot_in_ready_s),
        .out_payload (slot_out_s),
        .out_valid   (slot_valid_s),
        .out_ready   (bus.out_ready[slot_dest_s])
    );

    assign bus.in_ready  = slot_in_ready_s;
    assign bus.out_data  = slot_out_s[DATA_W-1:0];
    assign bus.out_last  = slot_out_s[DATA_W];
    assign bus.out_valid = slot_valid_s ? sel_onehot(slot_dest_s) : {NUM_OUT{1'b0}};
    assign bus.busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed bench for demux_1to4_stream with a beat scoreboard checked at every output transfer.
module tb_demux_1to4_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   w;
    logic [10:0] sb[$];

    demux_1to4_stream_if #(.DATA_W(8)) bus ();

    demux_1to4_stream #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat, wait for acceptance, record what the output must show.
    task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic last,
                        input logic [1:0] exp_dest, output int waits);
        bus.in_data  = d;
        bus.in_sel   = sel;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("accept", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready) sb.push_back({exp_dest, last, d});
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every consumer transfer pops and checks the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid != 4'b0000)
                chk("onehot", {31'd0, $onehot(bus.out_valid)}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", {21'd0, i[1:0], bus.out_last, bus.out_data}, 32'h7FF);
                    end else begin
                        chk("beat", {21'd0, i[1:0], bus.out_last, bus.out_data}, {21'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
        chk("rst_out_last",  {31'd0, bus.out_last}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

        // Single-beat packet to output 2.
        send(8'hA5, 2'd2, 1'b1, 2'd2, w);
        bus.in_valid = 1'b0;
        chk("single_valid", {28'd0, bus.out_valid}, 32'h4);
        chk("single_data",  {24'd0, bus.out_data}, 32'hA5);
        chk("single_last",  {31'd0, bus.out_last}, 32'd1);
        chk("single_busy",  {31'd0, bus.busy}, 32'd0);

        // Route lock: later in_sel values are ignored.
        send(8'h10, 2'd1, 1'b0, 2'd1, w);
        chk("lock_busy0", {31'd0, bus.busy}, 32'd1);
        send(8'h11, 2'd3, 1'b0, 2'd1, w);
        chk("lock_valid1", {28'd0, bus.out_valid}, 32'h2);
        send(8'h12, 2'd0, 1'b0, 2'd1, w);
        chk("lock_busy2", {31'd0, bus.busy}, 32'd1);
        send(8'h13, 2'd2, 1'b1, 2'd1, w);
        bus.in_valid = 1'b0;
        chk("lock_busy3", {31'd0, bus.busy}, 32'd0);
        chk("lock_valid3", {28'd0, bus.out_valid}, 32'h2);

        // Backpressure on output 0 for five cycles.
        bus.out_ready = 4'b1110;
        send(8'h20, 2'd0, 1'b0, 2'd0, w);
        bus.in_data = 8'h21;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold_data", {24'd0, bus.out_data}, 32'h20);
            chk("bp_hold_valid", {28'd0, bus.out_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 4'b1111;
        send(8'h21, 2'd2, 1'b0, 2'd0, w);
        send(8'h22, 2'd1, 1'b1, 2'd0, w);
        bus.in_valid = 1'b0;

        // Back-to-back packets: 2 beats to output 3, then 1 beat to output 1.
        send(8'h30, 2'd3, 1'b0, 2'd3, w);
        chk("b2b_valid0", {28'd0, bus.out_valid}, 32'h8);
        send(8'h31, 2'd0, 1'b1, 2'd3, w);
        chk("b2b_valid1", {28'd0, bus.out_valid}, 32'h8);
        send(8'h40, 2'd1, 1'b1, 2'd1, w);
        chk("b2b_no_bubble", w, 32'd0);
        chk("b2b_valid2", {28'd0, bus.out_valid}, 32'h2);
        bus.in_valid = 1'b0;

        // Reset mid-packet: the beat held in the slot is discarded.
        send(8'h50, 2'd2, 1'b0, 2'd2, w);
        send(8'h51, 2'd0, 1'b0, 2'd2, w);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (sb.size() > 0) void'(sb.pop_back());
        chk("mid_rst_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
        bus.out_ready = 4'b1111;
        send(8'h60, 2'd0, 1'b1, 2'd0, w);
        bus.in_valid = 1'b0;
        chk("post_rst_valid", {28'd0, bus.out_valid}, 32'h1);

        // Non-selected readies must not drain a beat for output 3.
        bus.out_ready = 4'b0111;
        send(8'h70, 2'd3, 1'b1, 2'd3, w);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nsel_valid", {28'd0, bus.out_valid}, 32'h8);
            chk("nsel_data",  {24'd0, bus.out_data}, 32'h70);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 4'b1111;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
